mux_rr_arbiter: RTL and testbench

// Round-robin arbiter/sequencer that shares one 4:1 one-bit gate-level mux among

---
 rtl/mux_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner sequencer for a shared 4:1 one-bit mux: drives sel, one-hot gnt, and a valid-qualified sample of the mux output.
// Optional MUX_ARB_LOCK_EN adds a lock input that holds the grant past MAX_HOLD.
module mux_rr_arbiter #(
  parameter int MAX_HOLD  = 8,
  parameter int GUARD_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_req,
  input  logic       i_mux_out,
`ifdef MUX_ARB_LOCK_EN
  input  logic       i_lock,
`endif
  output logic [1:0] o_sel,
  output logic [3:0] o_gnt,
  output logic       o_busy,
  output logic       o_data_q,
  output logic       o_data_vld
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYC - 1);
  localparam bit         HAS_GUARD  = (GUARD_CYC > 0);

  state_t     r_state, w_state_next;
  logic [1:0] r_sel, w_sel_next;
  logic [3:0] r_gnt, w_gnt_next;
  logic       r_busy, w_busy_next;
  logic       r_data_q, w_data_q_next;
  logic       r_data_vld, w_data_vld_next;
  logic [1:0] r_ptr, w_ptr_next;
  logic [7:0] r_hold_cnt, w_hold_next;
  logic [3:0] r_guard_cnt, w_guard_next;

  logic       w_lock;
  logic [3:0] w_req_rot;
  logic       w_arb_found;
  logic [1:0] w_arb_ofs;
  logic [1:0] w_arb_owner;
  logic       w_owner_req;
  logic       w_hold_max;
  logic       w_exit;

`ifdef MUX_ARB_LOCK_EN
  assign w_lock = i_lock;
`else
  assign w_lock = 1'b0;
`endif

  // Requests rotated so bit 0 is the current round-robin head (ptr).
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign w_req_rot[gi] = i_req[r_ptr + 2'(gi)];
  end

  always_comb begin
    w_arb_found = |w_req_rot;
    w_arb_ofs   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_arb_ofs = 2'(k);
      end
    end
  end

  assign w_arb_owner = r_ptr + w_arb_ofs;
  assign w_owner_req = i_req[r_sel];
  assign w_hold_max  = (r_hold_cnt == HOLD_LAST);
  // Lock only matters while the owner still requests; a dropped request always exits.
  assign w_exit      = !w_owner_req || (w_hold_max && !w_lock);

  always_comb begin
    w_state_next    = r_state;
    w_sel_next      = r_sel;
    w_gnt_next      = r_gnt;
    w_ptr_next      = r_ptr;
    w_hold_next     = r_hold_cnt;
    w_guard_next    = r_guard_cnt;
    w_data_q_next   = r_data_q;
    w_data_vld_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gnt_next = 4'b0000;
        if (w_arb_found) begin
          w_state_next = ST_GRANT;
          w_sel_next   = w_arb_owner;
          w_gnt_next   = 4'b0001 << w_arb_owner;
          w_hold_next  = 8'd0;
        end
      end
      ST_GRANT: begin
        w_data_q_next   = i_mux_out;
        w_data_vld_next = 1'b1;
        if (w_exit) begin
          w_gnt_next   = 4'b0000;
          w_ptr_next   = r_sel + 2'd1;
          w_guard_next = 4'd0;
          w_state_next = HAS_GUARD ? ST_GUARD : ST_IDLE;
        end else if (!w_hold_max) begin
          w_hold_next = r_hold_cnt + 8'd1;
        end
      end
      ST_GUARD: begin
        w_gnt_next = 4'b0000;
        if (r_guard_cnt == GUARD_LAST) begin
          w_state_next = ST_IDLE;
        end else begin
          w_guard_next = r_guard_cnt + 4'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = 4'b0000;
      end
    endcase
    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sel       <= 2'b00;
      r_gnt       <= 4'b0000;
      r_busy      <= 1'b0;
      r_data_q    <= 1'b0;
      r_data_vld  <= 1'b0;
      r_ptr       <= 2'b00;
      r_hold_cnt  <= 8'd0;
      r_guard_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_next;
      r_sel       <= w_sel_next;
      r_gnt       <= w_gnt_next;
      r_busy      <= w_busy_next;
      r_data_q    <= w_data_q_next;
      r_data_vld  <= w_data_vld_next;
      r_ptr       <= w_ptr_next;
      r_hold_cnt  <= w_hold_next;
      r_guard_cnt <= w_guard_next;
    end
  end

  assign o_sel      = r_sel;
  assign o_gnt      = r_gnt;
  assign o_busy     = r_busy;
  assign o_data_q   = r_data_q;
  assign o_data_vld = r_data_vld;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized requests checked against a
// transaction-level model (owner / cycles-granted / guard-left), with a behavioural 4:1 mux.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD  = 2;
  localparam int GUARD_CYC = 1;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] mux_in;
  logic       mux_out;
  logic       lock;
  logic [1:0] o_sel;
  logic [3:0] o_gnt;
  logic       o_busy;
  logic       o_data_q;
  logic       o_data_vld;

  int n_checks = 0;
  int n_errors = 0;

  mux_rr_arbiter #(
    .MAX_HOLD  (MAX_HOLD),
    .GUARD_CYC (GUARD_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (req),
    .i_mux_out  (mux_out),
`ifdef MUX_ARB_LOCK_EN
    .i_lock     (lock),
`endif
    .o_sel      (o_sel),
    .o_gnt      (o_gnt),
    .o_busy     (o_busy),
    .o_data_q   (o_data_q),
    .o_data_vld (o_data_vld)
  );

  // Shared gate-level mux modelled behaviourally.
  assign mux_out = mux_in[o_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 granted, 2 guard.
  int         m_mode, m_owner, m_ptr, m_cnt, m_gleft;
  logic [1:0] e_sel;
  logic [3:0] e_gnt;
  logic       e_busy, e_q, e_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_gleft = 0;
    e_sel = 2'b00; e_gnt = 4'b0000; e_busy = 1'b0; e_q = 1'b0; e_vld = 1'b0;
  endtask

  // Predicts outputs after the next rising edge given inputs held through it.
  task automatic model_step(input logic [3:0] r, input logic [3:0] mi, input logic lk);
    bit found;
    case (m_mode)
      0: begin
        e_vld = 1'b0;
        e_gnt = 4'b0000;
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && r[(m_ptr + k) % 4]) begin
            found   = 1;
            m_owner = (m_ptr + k) % 4;
          end
        end
        if (found) begin
          m_mode = 1;
          m_cnt  = 0;
          e_sel  = 2'(m_owner);
          e_gnt  = 4'(1 << m_owner);
        end
      end
      1: begin
        e_q   = mi[m_owner];
        e_vld = 1'b1;
        m_cnt++;
        if (!r[m_owner] || (m_cnt >= MAX_HOLD && !lk)) begin
          $display("grant src %0d held %0d cycles", m_owner, m_cnt);
          e_gnt = 4'b0000;
          m_ptr = (m_owner + 1) % 4;
          if (GUARD_CYC > 0) begin
            m_mode  = 2;
            m_gleft = GUARD_CYC;
          end else begin
            m_mode = 0;
          end
        end
      end
      default: begin
        e_vld = 1'b0;
        m_gleft--;
        if (m_gleft == 0) m_mode = 0;
      end
    endcase
    e_busy = (m_mode != 0);
  endtask

  task automatic check_outs();
    chk("sel",      32'(o_sel),      32'(e_sel));
    chk("gnt",      32'(o_gnt),      32'(e_gnt));
    chk("busy",     32'(o_busy),     32'(e_busy));
    chk("data_vld", 32'(o_data_vld), 32'(e_vld));
    if (e_vld) chk("data_q", 32'(o_data_q), 32'(e_q));
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] mi, input logic lk);
    logic lk_eff;
    @(negedge clk);
    check_outs();
    req    = r;
    mux_in = mi;
    lock   = lk;
`ifdef MUX_ARB_LOCK_EN
    lk_eff = lk;
`else
    lk_eff = 1'b0;
`endif
    model_step(r, mi, lk_eff);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_mode != 0; i++) step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
  endtask

  initial begin
    logic [3:0] rr;
    rst_n = 1'b0; req = 4'b0000; mux_in = 4'b0000; lock = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs();
    rst_n = 1'b1;

    // Single request, mux inputs 1011: owner 1 samples a 1.
    for (int i = 0; i < 3; i++) step(4'b0010, 4'b1011, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0000, 4'b1011, 1'b0);

    // Continuous all-request rotation.
    for (int i = 0; i < 24; i++) step(4'b1111, 4'($urandom), 1'b0);
    drain();

    // Wrap/skip: serve owner 3, then 0101 goes to 0 then 2.
    for (int i = 0; i < 20 && !(m_mode == 0 && m_ptr == 0); i++) step(4'b1000, 4'b0000, 1'b0);
    for (int i = 0; i < 12; i++) step(4'b0101, 4'($urandom), 1'b0);
    drain();

    // Request drop coinciding with the hold limit: one exit, next owner 1.
    step(4'b0001, 4'b0101, 1'b0);
    step(4'b0011, 4'b0101, 1'b0);
    step(4'b0010, 4'b0101, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b0010, 4'b0101, 1'b0);
    drain();

    // Asynchronous reset in the middle of a grant to owner 2.
    step(4'b0100, 4'b0100, 1'b0);
    @(posedge clk);
    #1;
    chk("gnt_before_rst", 32'(o_gnt), 32'(e_gnt));
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // Lock held for 20 cycles with 0011 (limit enforced when lock is absent).
    for (int i = 0; i < 21; i++) step(4'b0011, 4'b0011, 1'b1);
    for (int i = 0; i < 8; i++) step(4'b0011, 4'b0011, 1'b0);
    drain();

    // Randomized requests with persistence, random mux data and lock.
    rr = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) rr[b] = ~rr[b];
      step(rr, 4'($urandom), 1'($urandom_range(3) == 0));
    end
    step(4'b0000, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
